bsg_comm_link_serializer: RTL

Core-side transmit serializer that sits directly upstream of the comm link's core input port. It accepts one wide packet per ready/valid handshake from the core network, splits it into `els_p` beats of `width_p` bits, and presents the beats in order on the comm link's `core_valid_i`/`core_data_i`/`core_ready_o` port. Beats are issued only while the comm link reports calibration done.

---
 rtl/bsg_comm_link_serializer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bsg_comm_link_serializer.sv
// bsg_comm_link_serializer
//
// Core-side transmit serializer for the comm link. Takes one wide packet per
// ready/valid handshake from the core network and issues it as els_p beats
// of width_p bits on the comm link core input port, only while the link
// reports calibration done.
//
// Handshakes (both sides): a transfer happens in a cycle where valid and
// ready are both high at the rising edge; valid never depends on ready, data
// is held stable while valid is high and unaccepted. ready_o depends
// combinationally on link_ready_i so the next packet can load in the cycle
// of the last beat, giving back-to-back packets without a bubble.
//
// Configuration macro: BSG_COMM_LINK_SERIALIZER_MSB_FIRST_EN
//   undefined : least significant slice of the packet is beat 0
//   defined   : most significant slice of the packet is beat 0
//
// Ports:
//   clk_i         core clock (same as comm link core_clk_i)
//   reset_i       synchronous active-high reset
//   calib_done_i  comm link core_calib_done_r_o
//   v_i           input packet valid
//   data_i        input packet, packet_width_p bits
//   ready_o       block can accept a packet this cycle
//   link_v_o      beat valid  -> comm link core_valid_i
//   link_data_o   beat data   -> comm link core_data_i
//   link_ready_i  comm link core_ready_o
//   busy_o        a packet is held (FSM in SEND); this is the FSM state view

module bsg_comm_link_serializer #(
  parameter int width_p        = 8,
  parameter int els_p          = 4,
  parameter int packet_width_p = width_p * els_p
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      calib_done_i,
  input  logic                      v_i,
  input  logic [packet_width_p-1:0] data_i,
  output logic                      ready_o,
  output logic                      link_v_o,
  output logic [width_p-1:0]        link_data_o,
  input  logic                      link_ready_i,
  output logic                      busy_o
);

  localparam int cnt_w = $clog2(els_p);
  localparam logic [cnt_w-1:0] last_idx = cnt_w'(els_p - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                    state_r;
  logic [packet_width_p-1:0] pkt_r;
  logic [cnt_w-1:0]          cnt_r;

  logic last;
  logic beat_hs;
  logic in_hs;
  logic [cnt_w-1:0] sel;

  assign last     = (cnt_r == last_idx);
  assign link_v_o = (state_r == SEND) & calib_done_i;
  assign beat_hs  = link_v_o & link_ready_i;
  assign ready_o  = (state_r == IDLE) | ((state_r == SEND) & last & beat_hs);
  assign in_hs    = v_i & ready_o;
  assign busy_o   = (state_r == SEND);

`ifdef BSG_COMM_LINK_SERIALIZER_MSB_FIRST_EN
  assign sel = last_idx - cnt_r;
`else
  assign sel = cnt_r;
`endif

  // Explicit slice mux keeps the index arithmetic in constant expressions
  // and stays well defined when els_p is not a power of two.
  always_comb begin
    link_data_o = '0;
    for (int k = 0; k < els_p; k++) begin
      if (sel == cnt_w'(k)) begin
        link_data_o = pkt_r[k*width_p +: width_p];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      pkt_r   <= '0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_hs) begin
            pkt_r   <= data_i;
            cnt_r   <= '0;
            state_r <= SEND;
          end
        end
        SEND: begin
          if (beat_hs) begin
            if (last) begin
              cnt_r <= '0;
              // ready_o is high here, so v_i alone decides the reload.
              if (in_hs) begin
                pkt_r   <= data_i;
                state_r <= SEND;
              end else begin
                state_r <= IDLE;
              end
            end else begin
              cnt_r <= cnt_r + 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule
